// File: rtl/package_i2c.sv
// Command and state types shared by the I2C/SCCB command master and its users.
package package_i2c;

  typedef struct packed {
    logic       we;
    logic       sccb_mode;
    logic [6:0] addr_slave;
    logic [7:0] addr_reg;
    logic [7:0] burst_num;
  } t_i2c_cmd;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_ACK,
    S_RSTART,
    S_RDBIT,
    S_MACK,
    S_STOP
  } t_i2c_state;

endpackage

// File: rtl/i2c_cmd_master.sv
// Bit-level I2C/SCCB master: one command per handshake, single-register write or single-byte read,
// open-drain SCL/SDA driven through output enables (1 = pull low).
module i2c_cmd_master
  import package_i2c::*;
#(
  parameter int p_clk_hz = 25_000_000,
  parameter int p_scl_hz = 100_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  input  t_i2c_cmd   i_cmd_data,
  input  logic [7:0] i_wr_data,
  output logic       o_cmd_ready,
  output logic [7:0] o_rd_data,
  output logic       o_rd_valid,
  output logic       o_nack,
  output logic       o_busy,
  output logic       o_scl_oe,
  output logic       o_sda_oe,
  input  logic       i_sda_in,
  output t_i2c_state o_dbg_state
);

  localparam int c_quarter = p_clk_hz / (4 * p_scl_hz);
  localparam int c_cw      = (c_quarter > 2) ? $clog2(c_quarter) : 1;
  localparam logic [c_cw-1:0] c_qlast = c_cw'(c_quarter - 1);

  t_i2c_state state_q, state_d;
  logic [c_cw-1:0] qcnt_q, qcnt_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic [7:0] shreg_q, shreg_d;
  logic       ack_q, ack_d;
  logic       we_q, we_d;
  logic       sccb_q, sccb_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdat_q, wdat_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       nack_q, nack_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;
  logic       tick;
  logic       unused_burst;

  assign unused_burst = ^i_cmd_data.burst_num;

  // valid/ready: a command transfers on a rising edge where i_cmd_valid and o_cmd_ready are
  // both 1. Ready is high only in IDLE (and out of reset), so valid while busy is simply dropped.
  assign o_cmd_ready = (state_q == S_IDLE) && i_rst_n;
  assign o_busy      = (state_q != S_IDLE);
  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_nack      = nack_q;
  assign o_scl_oe    = scl_oe_q;
  assign o_sda_oe    = sda_oe_q;
  assign o_dbg_state = state_q;

  assign tick = (qcnt_q == c_qlast);

  always_comb begin
    state_d    = state_q;
    qcnt_d     = qcnt_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    shreg_d    = shreg_q;
    ack_d      = ack_q;
    we_d       = we_q;
    sccb_d     = sccb_q;
    addr_d     = addr_q;
    reg_d      = reg_q;
    wdat_d     = wdat_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    nack_d     = nack_q;
    scl_oe_d   = 1'b0;
    sda_oe_d   = 1'b0;

    if (state_q != S_IDLE) begin
      qcnt_d = tick ? '0 : qcnt_q + 1'b1;
    end

    if (state_q == S_IDLE) begin
      if (i_cmd_valid) begin
        state_d = S_START;
        qcnt_d  = '0;
        phase_d = 2'd0;
        bit_d   = 3'd0;
        byte_d  = 2'd0;
        we_d    = i_cmd_data.we;
        sccb_d  = i_cmd_data.sccb_mode;
        addr_d  = i_cmd_data.addr_slave;
        reg_d   = i_cmd_data.addr_reg;
        wdat_d  = i_wr_data;
        shreg_d = {i_cmd_data.addr_slave, 1'b0};
        nack_d  = 1'b0;
      end
    end else if (tick) begin
      phase_d = phase_q + 2'd1;
      // Receive-side sampling happens at the end of the second SCL-high quarter.
      if (phase_q == 2'd2 && state_q == S_ACK)   ack_d   = i_sda_in;
      if (phase_q == 2'd2 && state_q == S_RDBIT) shreg_d = {shreg_q[6:0], i_sda_in};
      if (phase_q == 2'd3) begin
        case (state_q)
          S_START: begin
            state_d = S_SHIFT;
            bit_d   = 3'd0;
          end
          S_RSTART: begin
            state_d = S_SHIFT;
            bit_d   = 3'd0;
            byte_d  = 2'd2;
            shreg_d = {addr_q, 1'b1};
          end
          S_SHIFT: begin
            if (bit_q == 3'd7) begin
              state_d = S_ACK;
            end else begin
              bit_d   = bit_q + 3'd1;
              shreg_d = {shreg_q[6:0], 1'b0};
            end
          end
          S_ACK: begin
            bit_d = 3'd0;
            if (!sccb_q && ack_q) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else begin
              case (byte_q)
                2'd0: begin
                  state_d = S_SHIFT;
                  shreg_d = reg_q;
                  byte_d  = 2'd1;
                end
                2'd1: begin
                  if (we_q) begin
                    state_d = S_SHIFT;
                    shreg_d = wdat_q;
                    byte_d  = 2'd2;
                  end else begin
                    state_d = S_STOP;
                  end
                end
                default: state_d = we_q ? S_STOP : S_RDBIT;
              endcase
            end
          end
          S_RDBIT: begin
            if (bit_q == 3'd7) begin
              state_d    = S_MACK;
              rd_data_d  = shreg_q;
              rd_valid_d = 1'b1;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          S_MACK: state_d = S_STOP;
          S_STOP: begin
            // A read stops after the register byte and restarts for the addr+R phase.
            state_d = (!we_q && byte_q == 2'd1 && !nack_q) ? S_RSTART : S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Pin enables are decoded from the next state so the pins themselves are registered.
    case (state_d)
      S_START, S_RSTART: begin
        scl_oe_d = (phase_d == 2'd3);
        sda_oe_d = (phase_d != 2'd0);
      end
      S_SHIFT: begin
        scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
        sda_oe_d = ~shreg_d[7];
      end
      S_ACK, S_RDBIT, S_MACK: begin
        scl_oe_d = (phase_d == 2'd0) || (phase_d == 2'd3);
        sda_oe_d = 1'b0;
      end
      S_STOP: begin
        scl_oe_d = (phase_d == 2'd0);
        sda_oe_d = (phase_d != 2'd3);
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      qcnt_q     <= '0;
      phase_q    <= 2'd0;
      bit_q      <= 3'd0;
      byte_q     <= 2'd0;
      shreg_q    <= 8'd0;
      ack_q      <= 1'b0;
      we_q       <= 1'b0;
      sccb_q     <= 1'b0;
      addr_q     <= 7'd0;
      reg_q      <= 8'd0;
      wdat_q     <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
      nack_q     <= 1'b0;
      scl_oe_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shreg_q    <= shreg_d;
      ack_q      <= ack_d;
      we_q       <= we_d;
      sccb_q     <= sccb_d;
      addr_q     <= addr_d;
      reg_q      <= reg_d;
      wdat_q     <= wdat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      nack_q     <= nack_d;
      scl_oe_q   <= scl_oe_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_master.sv
// Bench for i2c_cmd_master: bus-level slave model, token scoreboard and transaction-level reference.
module tb_i2c_cmd_master;
  import package_i2c::*;

  localparam int CLK_HZ = 1_600_000;
  localparam int SCL_HZ = 100_000;
  localparam int CQ     = CLK_HZ / (4 * SCL_HZ);
  localparam int W      = 11;
  localparam logic [W-1:0] TOK_START = {2'd0, 9'd0};
  localparam logic [W-1:0] TOK_STOP  = {2'd1, 9'd0};

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  t_i2c_cmd   cmd_data;
  logic [7:0] wr_data;
  logic       cmd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       nack;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_line;
  t_i2c_state dbg_state;
  logic       slave_pull;

  assign sda_line = ~sda_oe & ~slave_pull;

  i2c_cmd_master #(.p_clk_hz(CLK_HZ), .p_scl_hz(SCL_HZ)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd_data(cmd_data),
    .i_wr_data(wr_data), .o_cmd_ready(cmd_ready), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_nack(nack), .o_busy(busy), .o_scl_oe(scl_oe), .o_sda_oe(sda_oe), .i_sda_in(sda_line),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required the run to complete");
    $fatal(1, "watchdog timeout");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   rd_exp_q[$];
  logic         nack_exp_q[$];
  int           dur_exp_q[$];
  logic         mon_en = 1'b0;

  logic [6:0] sl_addr = 7'd0;
  logic       sl_present = 1'b0;
  logic [7:0] sl_rd = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] tok_byte(input logic [7:0] b, input logic ack);
    return {2'd2, ack, b};
  endfunction

  // Reference: the bus conversation a command should produce, as a list of START/STOP/byte tokens.
  task automatic push_expect(input t_i2c_cmd c, input logic [7:0] wd, input logic present,
                             input logic [7:0] rd);
    logic [W-1:0] toks[$];
    logic nak;
    int ticks;
    nak = ~present;
    toks.push_back(TOK_START);
    toks.push_back(tok_byte({c.addr_slave, 1'b0}, nak));
    if (!c.sccb_mode && nak) begin
      toks.push_back(TOK_STOP);
    end else begin
      toks.push_back(tok_byte(c.addr_reg, nak));
      if (c.we) begin
        toks.push_back(tok_byte(wd, nak));
        toks.push_back(TOK_STOP);
      end else begin
        toks.push_back(TOK_STOP);
        toks.push_back(TOK_START);
        toks.push_back(tok_byte({c.addr_slave, 1'b1}, nak));
        toks.push_back(tok_byte(present ? rd : 8'hFF, 1'b1));
        toks.push_back(TOK_STOP);
        rd_exp_q.push_back(present ? rd : 8'hFF);
      end
    end
    ticks = 0;
    foreach (toks[i]) begin
      ticks += (toks[i][W-1:W-2] == 2'd2) ? 36 : 4;
      exp_q.push_back(toks[i]);
    end
    nack_exp_q.push_back(!c.sccb_mode && nak);
    dur_exp_q.push_back(ticks * CQ);
  endtask

  task automatic sb_token(input logic [W-1:0] t);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL bus_token: got 0x%0h, required no bus activity", t);
    end else begin
      check("bus_token", t, exp_q.pop_front());
    end
  endtask

  // ---------------- bus monitor + slave model ----------------
  logic       prev_scl, prev_sda, pend_read, reading, addressed;
  logic [3:0] bitcnt;
  logic [8:0] bits;
  int         byte_no, run_len;

  always @(negedge clk) begin
    logic scl_n, sda_n;
    scl_n = ~scl_oe;
    sda_n = sda_line;
    if (!mon_en || !rst_n) begin
      bitcnt = 0; byte_no = 0; addressed = 0; pend_read = 0; reading = 0;
      slave_pull = 1'b0; run_len = 2 * CQ; bits = '0;
    end else begin
      if (scl_n != prev_scl) begin
        check("scl_phase_len_ok", (run_len >= 2 * CQ), 1);
        run_len = 1;
      end else begin
        run_len++;
      end
      if (prev_scl && scl_n && (prev_sda != sda_n)) begin
        sb_token(sda_n ? TOK_STOP : TOK_START);
        bitcnt = 0; byte_no = 0; addressed = 0; pend_read = 0; reading = 0;
        slave_pull = 1'b0;
      end else if (!prev_scl && scl_n) begin
        bits = {bits[7:0], sda_n};
        bitcnt++;
        if (bitcnt == 9) begin
          sb_token({2'd2, bits[0], bits[8:1]});
          if (reading && bits[0]) reading = 0;
          bitcnt = 0;
          byte_no++;
        end
      end else if (prev_scl && !scl_n) begin
        if (bitcnt == 0 && pend_read) begin
          reading = 1;
          pend_read = 0;
        end
        if (bitcnt == 8) begin
          if (reading) begin
            slave_pull = 1'b0;
          end else if (byte_no == 0) begin
            addressed  = sl_present && (bits[7:1] == sl_addr);
            pend_read  = addressed && bits[0];
            slave_pull = addressed;
          end else begin
            slave_pull = addressed;
          end
        end else begin
          slave_pull = reading ? ~sl_rd[7 - int'(bitcnt)] : 1'b0;
        end
      end
    end
    prev_scl = scl_n;
    prev_sda = sda_n;
  end

  // ---------------- result monitor ----------------
  logic ready_prev = 1'b1;
  logic rdv_prev = 1'b0;
  int   low_cnt = 0;

  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      ready_prev = cmd_ready;
      rdv_prev   = 1'b0;
      low_cnt    = 0;
    end else begin
      if (rd_valid) begin
        check("rd_valid_one_cycle", rdv_prev, 0);
        if (rd_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_valid: got pulse with data 0x%0h, required none", rd_data);
        end else begin
          check("rd_data", rd_data, rd_exp_q.pop_front());
        end
      end
      if (!ready_prev && cmd_ready) begin
        if (nack_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL txn_end: got unexpected completion, required none");
        end else begin
          check("nack_at_end", nack, nack_exp_q.pop_front());
          check("ready_low_clocks", low_cnt, dur_exp_q.pop_front());
        end
      end
      low_cnt    = cmd_ready ? 0 : low_cnt + 1;
      ready_prev = cmd_ready;
      rdv_prev   = rd_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int budget);
    int n = 0;
    while (!cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", cmd_ready, 1);
  endtask

  task automatic issue(input t_i2c_cmd c, input logic [7:0] wd, input logic present,
                       input logic [7:0] rd, input logic expect_it);
    wait_ready(1000);
    sl_addr = c.addr_slave;
    sl_present = present;
    sl_rd = rd;
    if (expect_it) push_expect(c, wd, present, rd);
    cmd_valid = 1'b1;
    cmd_data  = c;
    wr_data   = wd;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("ready_after_accept", cmd_ready, 0);
    check("busy_after_accept", busy, 1);
  endtask

  function automatic t_i2c_cmd rand_cmd();
    t_i2c_cmd c;
    c.we         = 1'($urandom_range(0, 1));
    c.sccb_mode  = 1'($urandom_range(0, 1));
    c.addr_slave = 7'($urandom_range(0, 127));
    c.addr_reg   = 8'($urandom_range(0, 255));
    c.burst_num  = 8'($urandom_range(0, 255));
    return c;
  endfunction

  task automatic rand_issue();
    issue(rand_cmd(), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)), 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    t_i2c_cmd c;
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_data = '0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ready", cmd_ready, 0);
    check("reset_scl_oe", scl_oe, 0);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_nack", nack, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_state", dbg_state, S_IDLE);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);
    mon_en = 1'b1;
    @(negedge clk);

    // SCCB write, nobody answers
    c = '{we: 1'b1, sccb_mode: 1'b1, addr_slave: 7'h21, addr_reg: 8'h12, burst_num: 8'h05};
    issue(c, 8'h80, 1'b0, 8'h00, 1'b1);
    // I2C write, nobody answers: stops after the address byte
    c = '{we: 1'b1, sccb_mode: 1'b0, addr_slave: 7'h21, addr_reg: 8'h12, burst_num: 8'h00};
    issue(c, 8'h80, 1'b0, 8'h00, 1'b1);
    // I2C read from a responding device
    c = '{we: 1'b0, sccb_mode: 1'b0, addr_slave: 7'h21, addr_reg: 8'h0A, burst_num: 8'h00};
    issue(c, 8'h00, 1'b1, 8'h7F, 1'b1);

    // parser-style back-to-back commands
    for (int i = 0; i < 10; i++) rand_issue();

    // valid pulsed while busy must be dropped
    c = '{we: 1'b1, sccb_mode: 1'b0, addr_slave: 7'h3C, addr_reg: 8'h55, burst_num: 8'h00};
    issue(c, 8'hA5, 1'b1, 8'h00, 1'b1);
    repeat (40) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = rand_cmd();
    wr_data   = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("ready_while_busy", cmd_ready, 0);

    // reset during the data byte of a write
    c = '{we: 1'b1, sccb_mode: 1'b1, addr_slave: 7'h10, addr_reg: 8'h20, burst_num: 8'h00};
    issue(c, 8'h00, 1'b1, 8'h00, 1'b1);
    wait_ready(1000);
    @(negedge clk);
    mon_en = 1'b0;
    issue(c, 8'h00, 1'b1, 8'h00, 1'b0);
    repeat ((76 + 10) * CQ) @(negedge clk);
    check("data_byte_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_scl_oe", scl_oe, 0);
    check("abort_sda_oe", sda_oe, 0);
    check("abort_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    check("abort_ready_held", cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after", cmd_ready, 1);
    check("abort_nack", nack, 0);
    check("abort_rd_data", rd_data, 0);
    check("abort_rd_valid", rd_valid, 0);
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 14; i++) rand_issue();

    wait_ready(1000);
    repeat (10) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("rd_exp_q_drained", rd_exp_q.size(), 0);
    check("nack_exp_q_drained", nack_exp_q.size(), 0);
    check("dur_exp_q_drained", dur_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
